// File: rtl/ml_ahb_arb_port_0.sv
`default_nettype none
// ============================================================================
// Module      : ml_ahb_arb_port_0
// Description : Two-master arbiter for multilayer AHB slave port 0. Chooses
//               the address-phase owner by priority with round-robin tie
//               break, keeps the grant through bursts and locked sequences,
//               and forces a hand-over once the fairness counter saturates.
//               Also tracks which master owns the data phase.
// Revision    : 1.0 - initial release
// ============================================================================
module ml_ahb_arb_port_0 #(
  parameter int PRIO_W   = 3,
  parameter int RR_EN    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [1:0]          req_i,
  input  logic [1:0]          lock_i,
  input  logic [2*PRIO_W-1:0] prio_i,
  input  logic [1:0]          owner_trans_i,
  input  logic                hready_i,
  output logic [1:0]          grant_o,
  output logic [1:0]          data_sel_o,
  output logic                hmastlock_o,
  output logic [1:0]          wait_o
);

  localparam int                  c_HOLD_W       = $clog2(MAX_HOLD + 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_MAX     = c_HOLD_W'(MAX_HOLD);
  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE     = c_HOLD_W'(1);
  localparam logic [1:0]          c_TRANS_IDLE   = 2'd0;
  localparam logic [1:0]          c_TRANS_NONSEQ = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  state_t                r_state;
  logic [1:0]            r_grant;
  logic [1:0]            r_data_sel;
  logic [c_HOLD_W-1:0]   r_hold_cnt;
  logic                  r_rr_last;

  logic [PRIO_W-1:0]     w_prio0;
  logic [PRIO_W-1:0]     w_prio1;
  logic                  w_win;
  logic                  w_owner;
  logic                  w_other;
  logic                  w_active;
  logic                  w_owner_lock;
  logic                  w_owner_req;
  logic                  w_other_req;
  logic                  w_hold_full;
  logic                  w_forced;
  logic                  w_ap;
  logic                  w_next_owner;
  logic                  w_stay_locked;
  logic [c_HOLD_W-1:0]   w_hold_next;

  assign w_prio0       = prio_i[PRIO_W-1:0];
  assign w_prio1       = prio_i[2*PRIO_W-1:PRIO_W];

  // The owner index is only meaningful while a grant exists (state != IDLE).
  assign w_owner       = r_grant[1];
  assign w_other       = ~w_owner;
  assign w_active      = owner_trans_i[1];
  assign w_owner_lock  = lock_i[w_owner];
  assign w_owner_req   = req_i[w_owner];
  assign w_other_req   = req_i[w_other];
  assign w_hold_full   = (r_hold_cnt >= c_HOLD_MAX);

  // Fairness expiry hands the port to the waiting master even if it has the
  // worse priority; otherwise the normal winner function decides.
  assign w_forced      = (owner_trans_i == c_TRANS_NONSEQ) && w_hold_full && w_other_req;
  assign w_ap          = (owner_trans_i == c_TRANS_IDLE) || !w_owner_req || w_forced;
  assign w_next_owner  = w_forced ? w_other : w_win;

  // Lock takes precedence over an arbitration point in the same cycle.
  assign w_stay_locked = w_owner_lock && ((r_state == ST_LOCK) || w_active);

  assign w_hold_next   = (w_active && w_other_req && !w_hold_full) ?
                         (r_hold_cnt + c_HOLD_ONE) : r_hold_cnt;

  // Winner: single requester wins, else lower prio, else round-robin / master 0.
  always_comb begin
    w_win = 1'b0;
    if (req_i == 2'b10) begin
      w_win = 1'b1;
    end else if (req_i == 2'b11) begin
      if (w_prio1 < w_prio0) begin
        w_win = 1'b1;
      end else if (w_prio1 == w_prio0) begin
        w_win = (RR_EN != 0) ? ~r_rr_last : 1'b0;
      end
    end
  end

  // Arbitration state, grant, fairness counter and data-phase owner tracking.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ST_IDLE;
      r_grant    <= 2'b00;
      r_data_sel <= 2'b00;
      r_hold_cnt <= '0;
      r_rr_last  <= 1'b1;
    end else if (hready_i) begin
      r_data_sel <= w_active ? r_grant : 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (|req_i) begin
            r_state    <= ST_OWN;
            r_grant    <= w_win ? 2'b10 : 2'b01;
            r_rr_last  <= w_win;
            r_hold_cnt <= '0;
          end
        end
        ST_OWN, ST_LOCK: begin
          if (w_stay_locked) begin
            r_state    <= ST_LOCK;
            r_hold_cnt <= w_hold_next;
          end else begin
            r_state <= ST_OWN;
            if (w_ap && (|req_i) && (w_next_owner != w_owner)) begin
              r_grant    <= w_next_owner ? 2'b10 : 2'b01;
              r_rr_last  <= w_next_owner;
              r_hold_cnt <= '0;
            end else begin
              r_hold_cnt <= w_hold_next;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  assign grant_o     = r_grant;
  assign data_sel_o  = r_data_sel;
  assign hmastlock_o = w_owner_lock & (|r_grant);
  assign wait_o      = req_i & ~r_grant;

endmodule
`default_nettype wire
